// File: rtl/imem_fetch_controller.sv
// imem_fetch_controller: fetch-stage sequencer for the pipelined MIPS core.
// Owns the PC, drives the instruction ROM address and registers the returned
// word into the IF/ID interface. Handles boot delay, stall, redirect,
// halt/resume and fetch-fault detection.
// Optional build macro: FETCH_PERF_CNT_EN enables the retired-fetch counter
// on FetchCtrl_FetchCount. When it is undefined the port is tied to zero.
module imem_fetch_controller #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 100,
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned BOOT_DELAY = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FetchCtrl_Stall,
  input  logic             FetchCtrl_RedirectValid,
  input  logic [WIDTH-1:0] FetchCtrl_RedirectPC,
  input  logic             FetchCtrl_Halt,
  input  logic             FetchCtrl_Resume,
  output logic [WIDTH-1:0] FetchCtrl_IMemPC,
  input  logic [WIDTH-1:0] FetchCtrl_IMemData,
  output logic [WIDTH-1:0] FetchCtrl_Instr,
  output logic [WIDTH-1:0] FetchCtrl_PCPlus4,
  output logic             FetchCtrl_Valid,
  output logic             FetchCtrl_Fault,
  output logic [1:0]       FetchCtrl_State,
  output logic [31:0]      FetchCtrl_FetchCount
);

  // Byte address one past the last legal instruction word.
  localparam int unsigned PC_LIMIT  = 4 * DEPTH;
  // Boot counter only needs to reach BOOT_DELAY-1.
  localparam int unsigned BOOT_LAST = (BOOT_DELAY > 0) ? (BOOT_DELAY - 1) : 0;
  localparam int unsigned BOOT_W    = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  state_t              r_state;
  logic [WIDTH-1:0]    r_pc;
  logic [WIDTH-1:0]    r_instr;
  logic [WIDTH-1:0]    r_pc_plus4;
  logic                r_valid;
  logic                r_fault;
  logic [BOOT_W-1:0]   r_boot_cnt;

  logic [WIDTH-1:0]    w_pc_next_seq;
  logic                w_pc_oob;
  logic                w_redir_legal;
  logic                w_boot_done;
  logic                w_fetch_fire;

  // Sequential PC, range check on the current PC, legality of the redirect target.
  assign w_pc_next_seq = r_pc + WIDTH'(4);
  assign w_pc_oob      = (r_pc >= WIDTH'(PC_LIMIT));
  assign w_redir_legal = (FetchCtrl_RedirectPC[1:0] == 2'b00) &&
                         (FetchCtrl_RedirectPC < WIDTH'(PC_LIMIT));
  // BOOT_DELAY of 0 or 1 leaves BOOT on the first edge; otherwise after BOOT_DELAY edges.
  assign w_boot_done   = (BOOT_DELAY <= 1) || (r_boot_cnt == BOOT_W'(BOOT_LAST));

  // A real instruction is captured this edge: unstalled RUN fetch from a legal PC.
  assign w_fetch_fire  = (r_state == ST_RUN) && !FetchCtrl_RedirectValid &&
                         !FetchCtrl_Halt && !FetchCtrl_Stall && !w_pc_oob;

  // Fetch sequencer: state, PC and IF/ID payload in one registered process.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_BOOT;
      r_pc       <= WIDTH'(RESET_PC);
      r_instr    <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
      r_boot_cnt <= '0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_valid <= 1'b0;
          if (w_boot_done) begin
            r_state <= ST_RUN;
          end else begin
            r_boot_cnt <= r_boot_cnt + BOOT_W'(1);
          end
        end

        ST_RUN: begin
          if (FetchCtrl_RedirectValid) begin
            // Wrong-path word is dropped; an illegal target faults immediately.
            r_pc    <= FetchCtrl_RedirectPC;
            r_valid <= 1'b0;
            if (!w_redir_legal) begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
            end
          end else if (FetchCtrl_Halt) begin
            r_state <= ST_HALTED;
            r_valid <= 1'b0;
          end else if (FetchCtrl_Stall) begin
            r_pc       <= r_pc;
            r_instr    <= r_instr;
            r_pc_plus4 <= r_pc_plus4;
            r_valid    <= r_valid;
          end else if (w_pc_oob) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
            r_valid <= 1'b0;
          end else begin
            r_instr    <= FetchCtrl_IMemData;
            r_pc_plus4 <= w_pc_next_seq;
            r_valid    <= 1'b1;
            r_pc       <= w_pc_next_seq;
          end
        end

        ST_HALTED: begin
          r_valid <= 1'b0;
          if (FetchCtrl_RedirectValid) begin
            r_pc <= FetchCtrl_RedirectPC;
          end else if (FetchCtrl_Resume && !FetchCtrl_Halt) begin
            r_state <= ST_RUN;
          end
        end

        ST_FAULT: begin
          r_valid <= 1'b0;
          if (FetchCtrl_RedirectValid && w_redir_legal) begin
            r_pc    <= FetchCtrl_RedirectPC;
            r_fault <= 1'b0;
            r_state <= ST_RUN;
          end
        end

        default: begin
          r_state <= ST_FAULT;
          r_fault <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;

  // Retired-fetch counter: advances only when a real instruction is captured.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fetch_count <= '0;
    end else if (w_fetch_fire) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign FetchCtrl_FetchCount = r_fetch_count;
`else
  assign FetchCtrl_FetchCount = 32'd0;
`endif

  // Address path is a direct copy of the PC register.
  assign FetchCtrl_IMemPC  = r_pc;
  assign FetchCtrl_Instr   = r_instr;
  assign FetchCtrl_PCPlus4 = r_pc_plus4;
  assign FetchCtrl_Valid   = r_valid;
  assign FetchCtrl_Fault   = r_fault;
  assign FetchCtrl_State   = 2'(r_state);

endmodule

// File: tb/tb_imem_fetch_controller.sv
// Directed bench for imem_fetch_controller with a behavioural 100-word ROM.
// Expected counter values follow FETCH_PERF_CNT_EN when it is defined.
module tb_imem_fetch_controller;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        halt;
  logic        resume;
  logic [31:0] imem_pc;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic        valid;
  logic        fault;
  logic [1:0]  state;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:99];

  int checks;
  int failures;

  imem_fetch_controller #(
    .WIDTH(32), .DEPTH(100), .RESET_PC(0), .BOOT_DELAY(2)
  ) dut (
    .CLK                     (clk),
    .RST                     (rst),
    .FetchCtrl_Stall         (stall),
    .FetchCtrl_RedirectValid (redir_valid),
    .FetchCtrl_RedirectPC    (redir_pc),
    .FetchCtrl_Halt          (halt),
    .FetchCtrl_Resume        (resume),
    .FetchCtrl_IMemPC        (imem_pc),
    .FetchCtrl_IMemData      (imem_data),
    .FetchCtrl_Instr         (instr),
    .FetchCtrl_PCPlus4       (pc_plus4),
    .FetchCtrl_Valid         (valid),
    .FetchCtrl_Fault         (fault),
    .FetchCtrl_State         (state),
    .FetchCtrl_FetchCount    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM: word-indexed by PC>>2, zero beyond 400 bytes.
  always_comb begin
    imem_data = 32'd0;
    if (imem_pc < 32'd400) imem_data = mem[imem_pc[8:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
`ifdef FETCH_PERF_CNT_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  // Advance one clock and sample 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 100; i++) mem[i] = 32'h1000_0000 | 32'(i);
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0007;

    rst = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_pc = 32'd0;
    halt = 1'b0; resume = 1'b0;
    #12;
    check("rst_state",  32'(state), 32'd0);
    check("rst_valid",  32'(valid), 32'd0);
    check("rst_pc",     imem_pc, 32'd0);
    check("rst_instr",  instr, 32'd0);
    check("rst_pcp4",   pc_plus4, 32'd0);
    check("rst_fault",  32'(fault), 32'd0);
    check("rst_count",  fetch_count, 32'd0);
    #10 rst = 1'b0;   // released at t=22, first edge at t=25

    // Boot delay: two idle edges before RUN, first fetch on the third.
    step();
    check("boot1_valid", 32'(valid), 32'd0);
    check("boot1_state", 32'(state), 32'd0);
    step();
    check("boot2_valid", 32'(valid), 32'd0);
    check("boot2_state", 32'(state), 32'd1);
    step();
    check("f0_instr", instr, 32'h2008_0005);
    check("f0_pcp4",  pc_plus4, 32'd4);
    check("f0_valid", 32'(valid), 32'd1);
    step();
    check("f1_instr", instr, 32'h2009_0007);
    check("f1_pcp4",  pc_plus4, 32'd8);
    check("f1_state", 32'(state), 32'd1);
    check("f1_pc",    imem_pc, 32'd8);

    // Stall three cycles at PC=8: everything holds.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_pc",    imem_pc, 32'd8);
      check("stall_instr", instr, 32'h2009_0007);
      check("stall_pcp4",  pc_plus4, 32'd8);
      check("stall_valid", 32'(valid), 32'd1);
    end
    stall = 1'b0;
    step();
    check("post_stall_instr", instr, 32'h1000_0002);
    check("post_stall_pcp4",  pc_plus4, 32'd12);

    // Redirect wins over a simultaneous stall.
    redir_valid = 1'b1; redir_pc = 32'h40; stall = 1'b1;
    step();
    redir_valid = 1'b0; stall = 1'b0;
    check("redir_valid", 32'(valid), 32'd0);
    check("redir_pc",    imem_pc, 32'h40);
    step();
    check("redir_instr", instr, 32'h1000_0010);
    check("redir_pcp4",  pc_plus4, 32'h44);
    step();
    check("seq_instr",   instr, 32'h1000_0011);
    check("count5",      fetch_count, cnt_exp(5));

    // Halt at PC=0x10; Resume with Halt keeps HALTED; Resume alone restarts.
    redir_valid = 1'b1; redir_pc = 32'h10;
    step();
    redir_valid = 1'b0;
    check("to10_pc", imem_pc, 32'h10);
    halt = 1'b1;
    step();
    check("halt_state", 32'(state), 32'd2);
    check("halt_valid", 32'(valid), 32'd0);
    resume = 1'b1; stall = 1'b1;
    step();
    check("halt_res_state", 32'(state), 32'd2);
    check("halt_pc",        imem_pc, 32'h10);
    halt = 1'b0; stall = 1'b0;
    step();
    resume = 1'b0;
    check("resume_state", 32'(state), 32'd1);
    check("resume_valid", 32'(valid), 32'd0);
    step();
    check("resume_instr", instr, 32'h1000_0004);
    check("resume_pcp4",  pc_plus4, 32'h14);

    // Run off the end of memory: last word fetched, then fault at 400.
    redir_valid = 1'b1; redir_pc = 32'h18C;
    step();
    redir_valid = 1'b0;
    step();
    check("last_instr", instr, 32'h1000_0063);
    check("last_pc",    imem_pc, 32'd400);
    step();
    check("oob_state", 32'(state), 32'd3);
    check("oob_fault", 32'(fault), 32'd1);
    check("oob_valid", 32'(valid), 32'd0);
    check("oob_pc",    imem_pc, 32'd400);
    redir_valid = 1'b1; redir_pc = 32'h2;
    step();
    check("bad_redir_state", 32'(state), 32'd3);
    check("bad_redir_fault", 32'(fault), 32'd1);
    check("bad_redir_pc",    imem_pc, 32'd400);
    redir_pc = 32'h0;
    step();
    redir_valid = 1'b0;
    check("recover_state", 32'(state), 32'd1);
    check("recover_fault", 32'(fault), 32'd0);
    check("recover_valid", 32'(valid), 32'd0);
    step();
    check("recover_instr", instr, 32'h2008_0005);
    check("recover_valid2", 32'(valid), 32'd1);
    check("count8", fetch_count, cnt_exp(8));

    // Out-of-range redirect from RUN faults directly.
    redir_valid = 1'b1; redir_pc = 32'h190;
    step();
    redir_valid = 1'b0;
    check("redir_oob_state", 32'(state), 32'd3);
    check("redir_oob_fault", 32'(fault), 32'd1);
    check("count_hold",      fetch_count, cnt_exp(8));

    // Recover, fetch once, then asynchronous reset mid-operation.
    redir_valid = 1'b1; redir_pc = 32'h4;
    step();
    redir_valid = 1'b0;
    step();
    check("pre_rst_instr", instr, 32'h2009_0007);
    #2 rst = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_pc",    imem_pc, 32'd0);
    check("arst_instr", instr, 32'd0);
    check("arst_count", fetch_count, 32'd0);
    #10 rst = 1'b0;
    step();
    step();
    step();
    check("reboot_instr", instr, 32'h2008_0005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the directed sequence is short; anything longer is a hang.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
